// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: shared state encoding and default widths for the clock period meter
package clk_meter_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;
  localparam int CNT_W_DEF = 16;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: multi-flop synchronizer plus rising-edge detector for an async input
// Ports: clkIn/rstIn (async, active-high) clock and reset, asyncIn raw input,
//        syncOut synchronized level, riseOut one-cycle pulse on a synchronized 0->1.
module edge_sync
  import clk_meter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clkIn,
  input  logic rstIn,
  input  logic asyncIn,
  output logic syncOut,
  output logic riseOut
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic hist_q;
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], asyncIn};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign syncOut = sync_q[SYNC_STAGES-1];
  assign riseOut = sync_q[SYNC_STAGES-1] & ~hist_q;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures clkIn cycles between rising edges of an async signal, with timeout
// Ports: clkIn/rstIn (async, active-high), enIn measurement enable, sigIn measured signal,
//        periodOut last period, validOut update strobe, timeoutOut sticky timeout,
//        armedOut high in ARM/MEAS, highOut high-time of the last period (CLK_PERIOD_METER_DUTY_EN only).
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CNT = 65535
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             enIn,
  input  logic             sigIn,
  output logic [CNT_W-1:0] periodOut,
  output logic             validOut,
  output logic             timeoutOut,
  output logic             armedOut
`ifdef CLK_PERIOD_METER_DUTY_EN
  ,
  output logic [CNT_W-1:0] highOut
`endif
);
  logic sync, rise;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic valid_q, valid_d, timeout_q, timeout_d, armed_q;
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clkIn  (clkIn),
    .rstIn  (rstIn),
    .asyncIn(sigIn),
    .syncOut(sync),
    .riseOut(rise)
  );
  // Priority: disable beats an edge, an edge beats timeout. cnt defaults to 0 so
  // every path that does not count explicitly clears it.
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    period_d = period_q;
    valid_d = 1'b0;
    timeout_d = timeout_q;
    if (!enIn) begin
      state_d = ST_IDLE;
      timeout_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_ARM;
    end else if (rise) begin
      state_d = ST_MEAS;
      cnt_d = CNT_W'(1);
      if (state_q == ST_MEAS) begin
        period_d = cnt_q;
        valid_d = 1'b1;
        timeout_d = 1'b0;
      end
    end else if (state_q == ST_MEAS) begin
      if (cnt_q == CNT_W'(TIMEOUT_CNT)) begin
        timeout_d = 1'b1;
        state_d = ST_ARM;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      state_d = ST_ARM;
    end
  end
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      period_q <= '0;
      valid_q <= 1'b0;
      timeout_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
      valid_q <= valid_d;
      timeout_q <= timeout_d;
      armed_q <= state_d != ST_IDLE;
    end
  end
  assign periodOut = period_q;
  assign validOut = valid_q;
  assign timeoutOut = timeout_q;
  assign armedOut = armed_q;
`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hi_q, hi_d, high_q, high_d;
  // hiCnt tracks cnt: restarts at 1 on the rise cycle (sync is high there) and
  // accumulates sync only while cnt is counting.
  always_comb begin
    hi_d = '0;
    high_d = valid_d ? hi_q : high_q;
    if (cnt_d == CNT_W'(1) && rise) hi_d = CNT_W'(1);
    else if (cnt_d != '0) hi_d = hi_q + CNT_W'(sync);
  end
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      hi_q <= '0;
      high_q <= '0;
    end else begin
      hi_q <= hi_d;
      high_q <= high_d;
    end
  end
  assign highOut = high_q;
`else
  logic unused_sync;
  assign unused_sync = sync;
`endif
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed stimulus with an edge-timestamp reference model and per-cycle compare
module tb_clk_period_meter;
  localparam int SY = 2;
  localparam int TO = 20;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sig = 1'b0;
  logic [15:0] periodOut;
  logic validOut, timeoutOut, armedOut;
`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [15:0] highOut;
`endif
  clk_period_meter #(.CNT_W(16), .SYNC_STAGES(SY), .TIMEOUT_CNT(TO)) dut (
    .clkIn(clk),
    .rstIn(rst),
    .enIn(en),
    .sigIn(sig),
    .periodOut(periodOut),
    .validOut(validOut),
    .timeoutOut(timeoutOut),
    .armedOut(armedOut)
`ifdef CLK_PERIOD_METER_DUTY_EN
    ,
    .highOut(highOut)
`endif
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  int cyc = 0, base = 0, last = 0, m_mode = 0, m_per = 0, m_hi = 0;
  bit m_val = 0, m_to = 0, rise;
  bit samp [int];
  int ncyc = 0, vlast = -1000, vgap = 0, t_to = -1, c, vc0;
  bit to_prev = 0;
  int vtimes [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask
  function automatic bit smp(input int j);
    return (j >= base && samp.exists(j)) ? samp[j] : 1'b0;
  endfunction
  function automatic int highs(input int a, input int b);
    int h = 0;
    for (int j = a; j < b; j++) h += int'(smp(j - SY));
    return h;
  endfunction
  // Model: each clk edge k stores sigIn; an edge is seen at k when the sample SY edges
  // earlier is 1 and the one before it is 0. Periods are differences of edge indices.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      base = cyc; m_mode = 0; m_to = 0; m_val = 0; m_per = 0; m_hi = 0;
    end else begin
      samp[cyc] = sig;
      rise = smp(cyc - SY) && !smp(cyc - SY - 1);
      m_val = 0;
      if (!en) begin
        m_mode = 0; m_to = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (rise) begin
        if (m_mode == 2) begin
          m_per = cyc - last; m_hi = highs(last, cyc); m_val = 1; m_to = 0;
        end
        m_mode = 2; last = cyc;
      end else if (m_mode == 2 && cyc - last == TO) begin
        m_to = 1; m_mode = 1;
      end
      cyc++;
    end
  end
  initial forever begin
    @(negedge clk);
    ncyc++;
    chk("periodOut", periodOut, m_per);
    chk("validOut", validOut, m_val);
    chk("timeoutOut", timeoutOut, m_to);
    chk("armedOut", armedOut, m_mode != 0);
`ifdef CLK_PERIOD_METER_DUTY_EN
    chk("highOut", highOut, m_hi);
`endif
    if (validOut) begin
      vtimes.push_back(ncyc);
      vgap = ncyc - vlast;
      vlast = ncyc;
    end
    if (timeoutOut && !to_prev) t_to = ncyc;
    to_prev = timeoutOut;
  end
  task automatic step(input logic s_, input logic e_);
    @(negedge clk);
    #1;
    sig = s_;
    en = e_;
  endtask
  task automatic steps(input logic s_, input logic e_, input int n);
    repeat (n) step(s_, e_);
  endtask
  task automatic pattern(input int hi, input int lo, input int n);
    repeat (n) begin
      steps(1'b1, 1'b1, hi);
      steps(1'b0, 1'b1, lo);
    end
  endtask
  task automatic restart;
    steps(1'b0, 1'b0, 4);
    step(1'b0, 1'b1);
  endtask
  function automatic int first_after(input int idx, input int origin);
    return (vtimes.size() > idx) ? vtimes[idx] - origin : -1;
  endfunction
  initial begin
    steps(1'b0, 1'b0, 3);
    chk("reset periodOut", periodOut, 0);
    chk("reset armedOut", armedOut, 0);
    chk("reset timeoutOut", timeoutOut, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    steps(1'b0, 1'b0, 2);
    chk("idle armedOut", armedOut, 0);
    // period 8: second edge driven at c+9, strobe seen SY+1 edges later
    restart;
    c = ncyc; vc0 = vtimes.size();
    pattern(4, 4, 6);
    steps(1'b0, 1'b1, 4);
    chk("p8 valid count", vtimes.size() - vc0, 5);
    chk("p8 first latency", first_after(vc0, c), 12);
    chk("p8 gap", vgap, 8);
    chk("p8 periodOut", periodOut, 8);
    chk("p8 model", m_per, 8);
    // minimum period 2
    restart;
    vc0 = vtimes.size();
    pattern(1, 1, 10);
    steps(1'b0, 1'b1, 4);
    chk("p2 valid count", vtimes.size() - vc0, 9);
    chk("p2 gap", vgap, 2);
    chk("p2 periodOut", periodOut, 2);
    // timeout 20 edges after entering MEAS, then recovery with period 10
    restart;
    c = ncyc; t_to = -1;
    steps(1'b1, 1'b1, 3);
    steps(1'b0, 1'b1, 30);
    chk("timeout latency", t_to - (c + 1), 23);
    chk("timeout set", timeoutOut, 1);
    chk("timeout periodOut held", periodOut, 2);
    chk("timeout armed", armedOut, 1);
    vc0 = vtimes.size();
    pattern(5, 5, 3);
    chk("p10 valid count", vtimes.size() - vc0, 2);
    chk("p10 periodOut", periodOut, 10);
    chk("p10 timeout cleared", timeoutOut, 0);
    // enable drop on the same edge as the rise
    vc0 = vtimes.size();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("endrop validOut", validOut, 0);
    chk("endrop armedOut", armedOut, 0);
    chk("endrop timeoutOut", timeoutOut, 0);
    steps(1'b0, 1'b0, 3);
    chk("endrop no strobe", vtimes.size() - vc0, 0);
    chk("endrop periodOut held", periodOut, 10);
    // enable drop clears a sticky timeout
    restart;
    steps(1'b1, 1'b1, 2);
    steps(1'b0, 1'b1, 25);
    chk("timeout2 set", timeoutOut, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("timeout2 cleared by enIn", timeoutOut, 0);
    // async reset mid-measurement
    restart;
    pattern(4, 4, 1);
    steps(1'b1, 1'b1, 4);
    steps(1'b0, 1'b1, 2);
    chk("pre-reset periodOut", periodOut, 8);
    @(negedge clk);
    #1;
    rst = 1'b1;
    sig = 1'b0;
    #1;
    chk("async periodOut", periodOut, 0);
    chk("async armedOut", armedOut, 0);
    chk("async timeoutOut", timeoutOut, 0);
    chk("async validOut", validOut, 0);
    steps(1'b0, 1'b1, 2);
    @(negedge clk);
    #1;
    rst = 1'b0;
    steps(1'b0, 1'b1, 2);
    c = ncyc; vc0 = vtimes.size();
    pattern(4, 4, 3);
    steps(1'b0, 1'b1, 4);
    chk("post-reset valid count", vtimes.size() - vc0, 2);
    chk("post-reset first latency", first_after(vc0, c), 12);
    chk("post-reset periodOut", periodOut, 8);
`ifdef CLK_PERIOD_METER_DUTY_EN
    restart;
    vc0 = vtimes.size();
    pattern(3, 5, 3);
    steps(1'b0, 1'b1, 4);
    chk("duty valid count", vtimes.size() - vc0, 2);
    chk("duty periodOut", periodOut, 8);
    chk("duty highOut", highOut, 3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
